sram_like_data_resp: RTL
========================

Name: sram_like_data_resp

Overview:
- Memory-side responder for the CPU data port on the SRAM-like handshake: req/addr_ok for the address phase, data_ok for the data phase.
- Receives size + byte address + unaligned store data from the core.
- Derives byte-lane write enables itself and performs the write.
- Returns reads as the raw 32-bit word; the core extracts and extends the bytes.
- Sits between the core's load/store path and a local byte-writable RAM; used in SoC simulation and as on-chip scratch data memory.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words stored (default 4096 words = 16 KB).
- LATENCY, 2, cycles from the accept edge to the data_ok cycle; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- data_req  in  1  request valid.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- data_addr  in  32  byte address.
- data_wdata  in  32  store data, already lane-replicated by the core.
- data_addr_ok  out  1  request accepted this cycle (level; accept = data_req & data_addr_ok).
- data_data_ok  out  1  one-cycle pulse: response valid.
- data_rdata  out  32  read word, valid while data_data_ok is high.

Behaviour:
- State machine: IDLE, WAIT, RESP. Reset state is IDLE. Reset values: data_data_ok = 0, data_rdata = 0, latency counter = 0.
- data_addr_ok = (state == IDLE). Combinational, and independent of data_req.
- Accept edge (IDLE & data_req):
  - latch wr, size, addr[1:0];
  - load counter with LATENCY-1;
  - go to RESP if LATENCY == 1, else go to WAIT.
- WAIT: decrement the counter each cycle; on the edge where the counter is 1, go to RESP. WAIT lasts LATENCY-1 cycles.
- RESP: data_data_ok = 1 for exactly one cycle, then IDLE. The next request can be accepted no earlier than cycle LATENCY+1 after the accept edge.
- Requests while not IDLE are not accepted; the requester holds data_req until it sees addr_ok.
- Alignment (misaligned = mis):
  - byte: always aligned;
  - half: addr[0] must be 0;
  - word: addr[1:0] must be 00;
  - size 3: always mis.
- Byte enables (big lane = byte 3):
  - byte: 0001, 0010, 0100, 1000 for addr[1:0] = 0..3;
  - half: 0011 for addr[1] = 0, 1100 for addr[1] = 1;
  - word: 1111;
  - mis: 0000.
- Store: RAM written on the accept edge using the enables above. data_wdata lanes are written as-is, with no shifting. data_rdata during a store response = 0.
- Load: synchronous RAM read at the accept edge. The word is registered into data_rdata and held stable from the cycle after accept through RESP. For mis loads, the aligned word is still returned.
- Word index = data_addr[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.
- RAM contents are not reset.
- resetn falling mid-transaction: an in-flight response is dropped and no data_ok is issued. A store already committed on its accept edge persists.
- Store followed by a load to the same word: the load sees the new data (the RAM write precedes any later accept).

Optional Feature:
- Macro SRAM_RESP_ERR_EN.
- Defined: adds output data_err (1 bit, reset 0). data_err = 1 together with data_data_ok for mis requests, else 0.
- Not defined: no data_err port. Mis stores are silently suppressed, and mis loads return the aligned word with no indication.

Decomposition:
- Shared package holds:
  - size encodings (SIZE_BYTE/HALF/WORD);
  - state enum (IDLE/WAIT/RESP);
  - byte-enable function (size, addr[1:0] -> 4-bit enable);
  - misalignment predicate.
- Sub-module byte_lane_ram: 2^DEPTH_LOG2 x 32 array with 4 independent byte write enables and a 1-cycle synchronous read.
- The top holds the FSM, counter and response registers.

Test Plan:
- Word store then load, LATENCY = 2:
  - store 0xDEADBEEF @ 0x100, size 2: addr_ok at cycle 0, data_ok at cycle 2;
  - load @ 0x100: data_rdata = 0xDEADBEEF with data_ok.
- Byte lanes: after word 0x00000000 @ 0x200, store size 0 @ 0x203 with wdata 0xABABABAB, then load @ 0x200 -> 0xAB000000. Half store @ 0x202 with wdata 0x12341234 -> word = 0x12340000.
- Misalignment: store word 0x55555555 @ 0x301 -> memory @ 0x300 unchanged. With SRAM_RESP_ERR_EN, data_err = 1 on that data_ok. Same for a half load @ 0x303.
- Back-to-back: data_req held high with LATENCY = 1 -> accepts every 2 cycles; data_ok pulses exactly 1 cycle; addr_ok = 0 during RESP.
- Wrap-around: DEPTH_LOG2 = 4, store 0x11111111 @ 0x40, load @ 0x00 -> 0x11111111.
- Reset mid-op: LATENCY = 3, drop resetn 1 cycle after a load is accepted -> no data_ok; after release, addr_ok = 1 and data_rdata = 0.

Source files
------------

// File: rtl/sram_like_data_resp_pkg.sv
//------------------------------------------------------------------------------
// Module   : sram_like_data_resp_pkg
// Purpose  : Shared definitions for the SRAM-like data-port responder:
//            access-size codes, FSM states, byte-enable and alignment helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_like_data_resp_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A request is misaligned when its address does not sit on a natural
  // boundary for its size; the reserved size code is always misaligned.
  function automatic logic is_mis(input logic [1:0] size, input logic [1:0] a);
    logic mis;
    mis = 1'b1;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = a[0];
      SIZE_WORD: mis = |a;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Lane enables with byte 3 as the most significant lane; a misaligned
  // request enables no lane at all so the store is dropped.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    if (!is_mis(size, a)) begin
      case (size)
        SIZE_BYTE: be = 4'b0001 << a;
        SIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
        SIZE_WORD: be = 4'b1111;
        default:   be = 4'b0000;
      endcase
    end
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_data_resp_byte_lane_ram.sv
//------------------------------------------------------------------------------
// Module   : byte_lane_ram
// Purpose  : 2^DEPTH_LOG2 x 32 storage with four independent byte write
//            enables and a registered (one-cycle) read port. Contents are not
//            reset; only the read register is.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_lane_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [c_depth];
  logic [31:0] r_rdata;

  // Byte-lane write: each enabled lane takes its own slice of wdata unshifted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register only updates on a read, so the word is held until the next one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'd0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_like_data_resp.sv
//------------------------------------------------------------------------------
// Module   : sram_like_data_resp
// Purpose  : Memory-side responder for a CPU data port on the SRAM-like
//            req/addr_ok/data_ok handshake, backed by a byte-writable RAM.
//            Optional macro SRAM_RESP_ERR_EN adds a data_err output flagging
//            misaligned requests alongside data_data_ok.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_like_data_resp
  import sram_like_data_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
`ifdef SRAM_RESP_ERR_EN
  ,
  output logic        data_err
`endif
);

  localparam logic [3:0] c_lat_m1    = 4'(LATENCY - 1);
  localparam logic       c_lat_is_one = (LATENCY == 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic                  r_data_ok;
  logic                  w_accept;
  logic                  w_to_resp;
  logic [3:0]            w_we;
  logic                  w_re;
  logic [31:0]           w_ram_q;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign data_addr_ok = (r_state == IDLE);
  assign w_accept     = (r_state == IDLE) & data_req;
  assign w_to_resp    = (w_accept & c_lat_is_one) | ((r_state == WAIT) & (r_cnt == 4'd1));

  assign w_idx = data_addr[DEPTH_LOG2+1:2];
  assign w_we  = (w_accept & data_wr) ? byte_en(data_size, data_addr[1:0]) : 4'b0000;
  assign w_re  = w_accept & ~data_wr;

  // Address bits above the array are deliberately ignored so accesses wrap.
  if (DEPTH_LOG2 < 30) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^data_addr[31:DEPTH_LOG2+2];
  end

  // Handshake FSM: accept in IDLE, count down in WAIT, pulse data_ok in RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_wr      <= 1'b0;
      r_data_ok <= 1'b0;
    end else begin
      r_data_ok <= w_to_resp;
      case (r_state)
        IDLE: begin
          if (data_req) begin
            r_wr    <= data_wr;
            r_cnt   <= c_lat_m1;
            r_state <= c_lat_is_one ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  byte_lane_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .resetn(resetn),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_idx),
    .wdata (data_wdata),
    .rdata (w_ram_q)
  );

  assign data_data_ok = r_data_ok;
  // Stores answer with zero; loads show the word captured at the accept edge.
  assign data_rdata   = r_wr ? 32'd0 : w_ram_q;

`ifdef SRAM_RESP_ERR_EN
  logic w_mis;
  logic r_mis;
  logic r_err;

  assign w_mis = is_mis(data_size, data_addr[1:0]);

  // Remember misalignment at accept and raise data_err with the data_ok pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mis <= w_mis;
      end
      r_err <= w_to_resp & ((r_state == IDLE) ? w_mis : r_mis);
    end
  end

  assign data_err = r_err;
`endif

endmodule

`default_nettype wire
